// File: rtl/regfile_dump.sv
// Debug dump reader for the 32x32 integer register file.
// Walks START_REG..END_REG through a dedicated read port and streams each
// value with its index over valid/ready, snooping writeback so every beat
// carries the most recently committed value of its register.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; read port parked at x0
// FETCH | read port drives ptr; value (or same-edge writeback) captured
// HOLD  | beat presented on the stream until the sink accepts it

module regfile_dump #(
   parameter int START_REG = 0,
   parameter int END_REG   = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   output logic [4:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_wdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_idx,
   output logic        out_last,
   output logic        busy,
   output logic        done
);

   if (START_REG < 0 || START_REG > END_REG || END_REG > 31) begin : g_bad_params
      $error("regfile_dump: need 0 <= START_REG <= END_REG <= 31");
   end

   localparam logic [4:0] START_IDX = 5'(START_REG);
   localparam logic [4:0] END_IDX   = 5'(END_REG);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [4:0]  ptr, ptr_nx;
   logic        valid_nx, last_nx, done_nx;
   logic [31:0] data_nx;
   logic [4:0]  idx_nx;
   logic        handshake;

   assign handshake = out_valid & out_ready;
   assign busy      = (state != IDLE);
   assign rf_raddr  = (state == FETCH) ? ptr : 5'd0;

   // State and stream output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 5'd0;
         out_valid <= 1'b0;
         out_data  <= 32'd0;
         out_idx   <= 5'd0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         out_valid <= valid_nx;
         out_data  <= data_nx;
         out_idx   <= idx_nx;
         out_last  <= last_nx;
         done      <= done_nx;
      end
   end

   // Next-state, capture with writeback bypass, and HOLD-time snoop
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      valid_nx = out_valid;
      data_nx  = out_data;
      idx_nx   = out_idx;
      last_nx  = out_last;
      done_nx  = 1'b0;

      case (state)
         IDLE: begin
            if (start && !abort) begin
               ptr_nx   = START_IDX;
               state_nx = FETCH;
            end
         end
         FETCH: begin
            // x0 is hardwired zero; a write landing this edge beats the stale read
            if (ptr == 5'd0)
               data_nx = 32'd0;
            else if (wb_we && wb_addr == ptr)
               data_nx = wb_wdata;
            else
               data_nx = rf_rdata;
            idx_nx   = ptr;
            last_nx  = (ptr == END_IDX);
            valid_nx = 1'b1;
            state_nx = HOLD;
         end
         HOLD: begin
            if (handshake) begin
               valid_nx = 1'b0;
               if (out_last) begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end else begin
                  ptr_nx   = ptr + 5'd1;
                  state_nx = FETCH;
               end
            end else if (wb_we && wb_addr == out_idx && out_idx != 5'd0) begin
               data_nx = wb_wdata;
            end
         end
         default: begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            last_nx  = 1'b0;
         end
      endcase

      if (abort && state != IDLE) begin
         state_nx = IDLE;
         valid_nx = 1'b0;
         last_nx  = 1'b0;
         done_nx  = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a register file model fed by the writeback port,
// directed scenarios on a 1..4 dumper and an x0-only dumper, then random
// dumps checked against the register file contents and expected index order.

module tb_regfile_dump;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, abort, wb_we, out_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_wdata;
   logic [4:0]  rf_raddr, out_idx;
   logic [31:0] rf_rdata, out_data;
   logic        out_valid, out_last, busy, done;

   logic        start0, abort0, out_ready0;
   logic [4:0]  rf_raddr0, out_idx0;
   logic [31:0] rf_rdata0, out_data0;
   logic        out_valid0, out_last0, busy0, done0;

   logic [31:0] regs [32];

   int checks   = 0;
   int failures = 0;

   assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : regs[rf_raddr];

   // Register file: writeback commits on the rising edge, x0 never written
   always @(posedge clk) begin
      if (wb_we && wb_addr != 5'd0) regs[wb_addr] <= wb_wdata;
   end

   regfile_dump #(.START_REG(1), .END_REG(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
   );

   regfile_dump #(.START_REG(0), .END_REG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
      .rf_raddr(rf_raddr0), .rf_rdata(rf_rdata0),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
      .out_idx(out_idx0), .out_last(out_last0), .busy(busy0), .done(done0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
      wb_we = 1'b1; wb_addr = a; wb_wdata = d;
      tick();
      wb_we = 1'b0;
   endtask

   function automatic logic [31:0] basic_val(input int i);
      case (i)
         1: return 32'h0000_0008;
         2: return 32'h0000_0009;
         3: return 32'hAAAA_AAAA;
         4: return 32'h5555_5555;
         default: return 32'h0;
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      wb_we = 1'b0; wb_addr = 5'd0; wb_wdata = 32'd0;
      start0 = 1'b0; abort0 = 1'b0; out_ready0 = 1'b0; rf_rdata0 = 32'd0;
      tick(); tick();
      checks++;
      if ({out_valid, out_last, done, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got valid/last/done/busy=%b want 0000",
                  {out_valid, out_last, done, busy});
      end
      checks++;
      if (out_data !== 32'd0 || out_idx !== 5'd0 || rf_raddr !== 5'd0) begin
         failures++;
         $display("FAIL reset_values got data=%h idx=%0d raddr=%0d want 0/0/0",
                  out_data, out_idx, rf_raddr);
      end
      rst_n = 1'b1;
      tick();
      for (int i = 1; i < 32; i++) rf_write(5'(i), $urandom);
      for (int i = 1; i <= 4; i++) rf_write(5'(i), basic_val(i));
   endtask

   task automatic test_basic_dump();
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || rf_raddr !== 5'd1) begin
         failures++;
         $display("FAIL basic_first_fetch got busy=%b valid=%b raddr=%0d want 1/0/1",
                  busy, out_valid, rf_raddr);
      end
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c <= 7 && (c % 2) == 1) begin
            int ei;
            ei = (c + 1) / 2;
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 5'(ei) || out_data !== basic_val(ei) ||
                out_last !== (ei == 4)) begin
               failures++;
               $display("FAIL basic_beat%0d got v=%b idx=%0d data=%h last=%b want 1/%0d/%h/%b",
                        ei, out_valid, out_idx, out_data, out_last, ei, basic_val(ei), ei == 4);
            end
         end else if (c < 8) begin
            checks++;
            if (out_valid !== 1'b0 || rf_raddr !== 5'(c / 2 + 1) || done !== 1'b0) begin
               failures++;
               $display("FAIL basic_fetch c=%0d got v=%b raddr=%0d done=%b want 0/%0d/0",
                        c, out_valid, rf_raddr, done, c / 2 + 1);
            end
         end else if (c == 8) begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
               failures++;
               $display("FAIL basic_done got done=%b busy=%b v=%b want 1/0/0",
                        done, busy, out_valid);
            end
         end else begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
               failures++;
               $display("FAIL basic_done_pulse got done=%b busy=%b want 0/0", done, busy);
            end
         end
      end
   endtask

   task automatic test_x0_bypass();
      rf_rdata0 = 32'hDEAD_BEEF;
      out_ready0 = 1'b0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wb_we = 1'b1; wb_addr = 5'd0; wb_wdata = 32'h1111_1111;
      tick();
      checks++;
      if (out_valid0 !== 1'b1 || out_idx0 !== 5'd0 || out_data0 !== 32'd0 || out_last0 !== 1'b1) begin
         failures++;
         $display("FAIL x0_beat got v=%b idx=%0d data=%h last=%b want 1/0/00000000/1",
                  out_valid0, out_idx0, out_data0, out_last0);
      end
      tick();
      checks++;
      if (out_data0 !== 32'd0 || out_valid0 !== 1'b1) begin
         failures++;
         $display("FAIL x0_snoop got data=%h v=%b want 00000000/1", out_data0, out_valid0);
      end
      wb_we = 1'b0;
      out_ready0 = 1'b1;
      tick();
      out_ready0 = 1'b0;
      checks++;
      if (done0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL x0_done got done=%b v=%b busy=%b want 1/0/0", done0, out_valid0, busy0);
      end
      tick();
   endtask

   task automatic test_stall_and_bypass();
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      out_ready = 1'b0;
      tick();
      for (int s = 1; s <= 5; s++) begin
         wb_we = (s == 3); wb_addr = 5'd2; wb_wdata = 32'h1234_5678;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_idx !== 5'd2 ||
             out_data !== ((s >= 3) ? 32'h1234_5678 : 32'h9)) begin
            failures++;
            $display("FAIL stall_s%0d got v=%b idx=%0d data=%h want 1/2/%h",
                     s, out_valid, out_idx, out_data, (s >= 3) ? 32'h1234_5678 : 32'h9);
         end
      end
      wb_we = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || rf_raddr !== 5'd3) begin
         failures++;
         $display("FAIL stall_release got v=%b raddr=%0d want 0/3", out_valid, rf_raddr);
      end
      wb_we = 1'b1; wb_addr = 5'd3; wb_wdata = 32'hCAFE_F00D;
      tick();
      wb_we = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 5'd3 || out_data !== 32'hCAFE_F00D) begin
         failures++;
         $display("FAIL fetch_bypass got v=%b idx=%0d data=%h want 1/3/cafef00d",
                  out_valid, out_idx, out_data);
      end
      tick();
      tick();
      checks++;
      if (out_idx !== 5'd4 || out_data !== 32'h5555_5555 || out_last !== 1'b1) begin
         failures++;
         $display("FAIL stall_last got idx=%0d data=%h last=%b want 4/55555555/1",
                  out_idx, out_data, out_last);
      end
      tick();
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL stall_done got done=%b want 1", done);
      end
      tick();
   endtask

   task automatic drain();
      logic seen;
      seen = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 40 && !seen; c++) begin
         tick();
         if (done) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL drain_timeout got done=0 want done within 40 cycles");
      end
      tick();
   endtask

   task automatic test_abort();
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      out_ready = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL abort got v=%b busy=%b done=%b last=%b want 0/0/0/0",
                  out_valid, busy, done, out_last);
      end
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_vs_start got busy=%b want 0", busy);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 5'd1) begin
         failures++;
         $display("FAIL abort_restart got v=%b idx=%0d want 1/1", out_valid, out_idx);
      end
      drain();
   endtask

   task automatic test_reset_mid_dump();
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({out_valid, out_last, done, busy} !== 4'b0000 || out_data !== 32'd0 ||
          out_idx !== 5'd0 || rf_raddr !== 5'd0) begin
         failures++;
         $display("FAIL reset_mid got v/l/d/b=%b data=%h idx=%0d raddr=%0d want all 0",
                  {out_valid, out_last, done, busy}, out_data, out_idx, rf_raddr);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_done got done=%b busy=%b want 0/0", done, busy);
      end
   endtask

   task automatic test_start_while_busy();
      int beats;
      int dones;
      beats = 0; dones = 0;
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      for (int c = 0; c < 30; c++) begin
         start = busy;
         if (out_valid && out_ready) beats++;
         tick();
         if (done) dones++;
      end
      start = 1'b0;
      checks++;
      if (beats != 4 || dones != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL start_while_busy got beats=%0d dones=%0d busy=%b want 4/1/0",
                  beats, dones, busy);
      end
   endtask

   task automatic test_random();
      for (int d = 0; d < 20; d++) begin
         int exp_next;
         logic finished;
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) tick();
         start = 1'b1;
         tick();
         start = 1'b0;
         exp_next = 1;
         finished = 1'b0;
         for (int c = 0; c < 200 && !finished; c++) begin
            logic pre_hs, pre_valid, pre_last;
            logic [4:0] pre_idx;
            out_ready = ($urandom_range(0, 99) < 60);
            wb_we     = ($urandom_range(0, 99) < 40);
            wb_addr   = 5'($urandom_range(0, 7));
            wb_wdata  = $urandom;
            pre_valid = out_valid;
            pre_hs    = out_valid && out_ready;
            pre_idx   = out_idx;
            pre_last  = out_last;
            tick();
            if (pre_hs) begin
               checks++;
               if (pre_idx !== 5'(exp_next) || pre_last !== (exp_next == 4)) begin
                  failures++;
                  $display("FAIL rand_order d=%0d got idx=%0d last=%b want %0d/%b",
                           d, pre_idx, pre_last, exp_next, exp_next == 4);
               end
               if (exp_next == 4) begin
                  finished = 1'b1;
                  checks++;
                  if (done !== 1'b1 || busy !== 1'b0) begin
                     failures++;
                     $display("FAIL rand_done d=%0d got done=%b busy=%b want 1/0", d, done, busy);
                  end
               end
               exp_next++;
            end else if (pre_valid) begin
               checks++;
               if (out_valid !== 1'b1 || out_idx !== pre_idx) begin
                  failures++;
                  $display("FAIL rand_hold d=%0d got v=%b idx=%0d want 1/%0d",
                           d, out_valid, out_idx, pre_idx);
               end
            end
            if (!finished && done) begin
               checks++;
               failures++;
               $display("FAIL rand_spurious_done d=%0d got done=1 want 0", d);
            end
            if (out_valid) begin
               logic [31:0] want;
               want = (out_idx == 5'd0) ? 32'd0 : regs[out_idx];
               checks++;
               if (out_data !== want) begin
                  failures++;
                  $display("FAIL rand_data d=%0d idx=%0d got %h want %h",
                           d, out_idx, out_data, want);
               end
            end
         end
         wb_we = 1'b0;
         if (!finished) begin
            checks++;
            failures++;
            $display("FAIL rand_timeout d=%0d got no final beat want done within 200 cycles", d);
         end
      end
      out_ready = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_dump();
      test_x0_bypass();
      test_stall_and_bypass();
      test_abort();
      test_reset_mid_dump();
      test_start_while_busy();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got simulation still running want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug/inspection reader for the 32x32 integer register file.
- On a start pulse it walks registers START_REG..END_REG through a dedicated combinational read port.
- Each value goes out on a valid/ready stream with its index.
- It snoops the writeback port so that each emitted value reflects the latest committed write.
- Sits beside the pipeline, between the register file and a debug/trace sink (UART bridge, testbench monitor).

Parameters:
- START_REG, 0, first register index dumped (0..31).
- END_REG, 31, last register index dumped (START_REG..31).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle request to begin a dump; ignored unless idle.
- abort  input  1  terminates the dump; takes priority over everything except reset.
- rf_raddr  output  5  address driven to the register file read port.
- rf_rdata  input  32  combinational read data for rf_raddr; x0 must read as zero.
- wb_we  input  1  writeback write enable (same signal as the register-file write enable).
- wb_addr  input  5  writeback destination register.
- wb_wdata  input  32  writeback data.
- out_valid  output  1  out_data/out_idx/out_last are valid.
- out_ready  input  1  sink accepts the current beat.
- out_data  output  32  register value.
- out_idx  output  5  register index of out_data.
- out_last  output  1  high with the beat for END_REG.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst_n=0 at a clock edge), all registered outputs:
  - state=IDLE.
  - out_valid=0, out_data=0, out_idx=0, out_last=0.
  - done=0, busy=0.
  - rf_raddr=0.
  - Reset mid-dump discards everything; no done pulse.
- States:
  - IDLE: rf_raddr=0. start=1 -> ptr=START_REG, go FETCH.
  - FETCH (1 cycle): rf_raddr=ptr. At the edge:
    - out_data = rf_rdata.
    - Bypass: if wb_we=1, wb_addr=ptr and ptr!=0, out_data = wb_wdata instead (write landing this same edge wins).
    - ptr=0 always yields out_data=0, regardless of rf_rdata or wb.
    - out_idx=ptr, out_last=(ptr==END_REG), out_valid=1, go HOLD.
  - HOLD: out_valid=1; outputs stable except for snoop updates.
    - Snoop: if wb_we=1, wb_addr=out_idx, out_idx!=0 and no handshake this cycle, out_data<=wb_wdata next edge.
    - Handshake (out_valid & out_ready) with out_last=0: out_valid<=0, ptr<=ptr+1, go FETCH.
    - Handshake with out_last=1: out_valid<=0, done<=1 for exactly one cycle, go IDLE.
- Throughput: one beat per 2 cycles when out_ready is held high.
- Latency: start at edge N -> FETCH in cycle N+1 -> out_valid high from edge N+2.
- Total beats per dump = END_REG-START_REG+1; ptr never wraps past END_REG.
- busy=1 in FETCH and HOLD; the done cycle has busy=0.
- abort=1 in any non-IDLE state: next edge state=IDLE, out_valid=0, out_last=0, done stays 0. abort in IDLE has no effect.
- start while busy is ignored. start and abort together in IDLE: abort wins, stays IDLE.
- start in the same cycle as done: accepted, new dump begins.
- Valid/ready rules: out_valid never drops without a handshake (except abort/reset). out_data changes during HOLD only via snoop.
- Parameter legality (elaboration check): 0<=START_REG<=END_REG<=31.

Test Plan:
- Register file preloaded x1=0x8, x2=0x9, x3=0xAAAAAAAA, x4=0x55555555, START_REG=1, END_REG=4, out_ready=1, start pulse -> 4 beats (1,0x8), (2,0x9), (3,0xAAAAAAAA), (4,0x55555555) on cycles N+2, N+4, N+6, N+8. out_last only on idx 4. done pulse at N+9. busy low at N+9.
- START_REG=0, END_REG=0, rf_rdata forced 0xDEADBEEF, wb_we=1 wb_addr=0 -> single beat idx 0, data 0x00000000, out_last=1.
- out_ready low for 5 cycles during x2 beat, wb_we=1 wb_addr=2 wb_wdata=0x12345678 at cycle 3 of the stall -> out_data becomes 0x12345678. Beat held until out_ready=1. Then x3 fetched.
- In FETCH of x3, wb_we=1 wb_addr=3 wb_wdata=0xCAFEF00D -> beat idx 3 carries 0xCAFEF00D.
- abort asserted while HOLD on x2 -> next cycle out_valid=0, busy=0, no done. A following start restarts from x1.
- rst_n=0 for 1 cycle mid-dump -> all outputs 0 next cycle. start during busy (second pulse) produces no extra beats.
